// File: rtl/recorder_pkg.sv
// Shared recorder definitions: session state encoding (matches the control FSM
// mode encoding) and default sizing constants.
package recorder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REC  = 2'b01,
        PLAY = 2'b10
    } state_t;

    localparam int unsigned NUM_CELLS_DEF   = 30;
    localparam int unsigned TICK_CYCLES_DEF = 50000000;

endpackage

// File: rtl/slot_timer.sv
// Slot timer: counts 0..TICK_CYCLES-1 while run is high and flags the last
// cycle of each slot on tick. clear holds the count at zero.
module slot_timer
    import recorder_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == LAST);

    // Free-running slot counter that wraps on the boundary cycle.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/key_sequence_store.sv
// Key sequence store: records the OR of the key vector over each slot period
// into a small slot RAM and replays it on key_out.
// Optional build macro KEY_STORE_LIVE_MONITOR_EN: key_out follows keys (one
// cycle late) in IDLE and REC; otherwise key_out is 0 outside PLAY.
module key_sequence_store
    import recorder_pkg::*;
#(
    parameter int unsigned NUM_CELLS   = NUM_CELLS_DEF,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned KEY_W       = 4,
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              recording,
    input  logic              playing_back,
    input  logic [KEY_W-1:0]  keys,
    output logic [KEY_W-1:0]  key_out,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

    state_t            state, state_next;
    logic [KEY_W-1:0]  acc, acc_next;
    logic [ADDR_W-1:0] address_next;
    logic              done_next;
    logic              wr_en;
    logic [KEY_W-1:0]  live_next;
    logic              tick;

    logic [KEY_W-1:0]  ram [NUM_CELLS];

    slot_timer #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_slot_timer (
        .clock (clock),
        .reset (reset),
        .clear (state == IDLE),
        .run   (state != IDLE),
        .tick  (tick)
    );

    // Session sequencing: entry, slot advance, last-slot completion and abort.
    always_comb begin
        state_next   = state;
        acc_next     = '0;
        address_next = address;
        done_next    = 1'b0;
        wr_en        = 1'b0;
        unique case (state)
            IDLE: begin
                address_next = '0;
                if (recording) begin
                    state_next = REC;
                end else if (playing_back) begin
                    state_next = PLAY;
                end
            end
            REC: begin
                acc_next = acc | keys;
                if (!recording) begin
                    state_next   = IDLE;
                    address_next = '0;
                    acc_next     = '0;
                end else if (tick) begin
                    wr_en    = 1'b1;
                    acc_next = '0;
                    if (address == LAST_ADDR) begin
                        done_next    = 1'b1;
                        state_next   = IDLE;
                        address_next = '0;
                    end else begin
                        address_next = address + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (!playing_back) begin
                    state_next   = IDLE;
                    address_next = '0;
                end else if (tick) begin
                    if (address == LAST_ADDR) begin
                        done_next    = 1'b1;
                        state_next   = IDLE;
                        address_next = '0;
                    end else begin
                        address_next = address + 1'b1;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                address_next = '0;
            end
        endcase
    end

    // Value driven on key_out whenever the block is not replaying.
    always_comb begin
`ifdef KEY_STORE_LIVE_MONITOR_EN
        live_next = (state == PLAY) ? '0 : keys;
`else
        live_next = '0;
`endif
    end

    // Control and output registers; busy and done are registered with the state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            address <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            key_out <= '0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            address <= address_next;
            busy    <= (state_next != IDLE);
            done    <= done_next;
            key_out <= (state == PLAY) ? ram[address] : live_next;
        end
    end

    // Slot RAM write; the boundary cycle's keys are folded into the stored value.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            ram[address] <= acc | keys;
        end
    end

endmodule

// File: tb/tb_key_sequence_store.sv
// Bench for key_sequence_store with TICK_CYCLES=4, NUM_CELLS=3. Expected values
// come from a slot-level model: slot s holds the OR of all keys seen during
// cycles s*T..s*T+T-1 of a record session; playback cycle k shows slot (k-1)/T.
module tb_key_sequence_store;

    localparam int unsigned NC = 3;
    localparam int unsigned TC = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned KW = 4;
    localparam int unsigned NT = NC * TC;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          recording = 1'b0;
    logic          playing_back = 1'b0;
    logic [KW-1:0] keys = '0;
    logic [KW-1:0] key_out;
    logic [AW-1:0] address;
    logic          busy;
    logic          done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [KW-1:0] model_ram [NC];
    logic [KW-1:0] seq [NT];
    logic [KW-1:0] prev_keys = '0;

    always #5 clock = ~clock;

    key_sequence_store #(
        .NUM_CELLS   (NC),
        .ADDR_W      (AW),
        .KEY_W       (KW),
        .TICK_CYCLES (TC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .recording    (recording),
        .playing_back (playing_back),
        .keys         (keys),
        .key_out      (key_out),
        .address      (address),
        .busy         (busy),
        .done         (done)
    );

    task automatic step();
        prev_keys = keys;
        @(posedge clock);
        #1;
    endtask

    // key_out expected outside PLAY: last cycle's keys with live monitor, else 0.
    function automatic logic [KW-1:0] idle_exp();
`ifdef KEY_STORE_LIVE_MONITOR_EN
        return prev_keys;
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [KW-1:0] k, input int a,
                           input logic b, input logic d);
        chk({tag, ".key_out"}, 32'(key_out), 32'(k));
        chk({tag, ".address"}, 32'(address), 32'(a));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(NT); i++) begin
            seq[i] = ($urandom_range(3) == 0) ? KW'($urandom_range(15)) : '0;
        end
    endtask

    // Record session; reset_at >= 0 asserts reset at that session cycle.
    task automatic record(input string tag, input logic both, input int reset_at);
        logic [KW-1:0] slot_or;
        recording    = 1'b1;
        playing_back = both;
        keys         = seq[0];
        step();
        for (int k = 0; k < int'(NT); k++) begin
            keys = seq[k];
            if (k == reset_at) begin
                reset = 1'b0;
                step();
                chk_all({tag, ".rst0"}, '0, 0, 1'b0, 1'b0);
                recording    = 1'b0;
                playing_back = 1'b0;
                keys         = '0;
                step();
                chk_all({tag, ".rst1"}, '0, 0, 1'b0, 1'b0);
                reset = 1'b1;
                step();
                chk_all({tag, ".post_rst"}, idle_exp(), 0, 1'b0, 1'b0);
                return;
            end
            chk_all({tag, ".rec"}, idle_exp(), k / int'(TC), 1'b1, 1'b0);
            if (k % int'(TC) == int'(TC) - 1) begin
                slot_or = '0;
                for (int j = k - int'(TC) + 1; j <= k; j++) slot_or |= seq[j];
                model_ram[k / int'(TC)] = slot_or;
            end
            step();
        end
        chk_all({tag, ".done"}, idle_exp(), 0, 1'b0, 1'b1);
        recording    = 1'b0;
        playing_back = 1'b0;
        keys         = '0;
        step();
        chk_all({tag, ".after"}, idle_exp(), 0, 1'b0, 1'b0);
    endtask

    // Playback session; abort_at >= 0 drops playing_back at that session cycle.
    task automatic play(input string tag, input int abort_at);
        playing_back = 1'b1;
        recording    = 1'b0;
        keys         = '0;
        step();
        for (int k = 0; k < int'(NT); k++) begin
            if (k == abort_at) begin
                playing_back = 1'b0;
                chk_all({tag, ".abort"}, model_ram[(k - 1) / int'(TC)], k / int'(TC), 1'b1,
                        1'b0);
                step();
                chk_all({tag, ".abort_idle"}, model_ram[k / int'(TC)], 0, 1'b0, 1'b0);
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk_all({tag, ".abort_quiet"}, idle_exp(), 0, 1'b0, 1'b0);
                end
                return;
            end
            chk_all({tag, ".play"}, (k == 0) ? idle_exp() : model_ram[(k - 1) / int'(TC)],
                    k / int'(TC), 1'b1, 1'b0);
            step();
        end
        chk_all({tag, ".done"}, model_ram[NC-1], 0, 1'b0, 1'b1);
        playing_back = 1'b0;
        step();
        chk_all({tag, ".after"}, idle_exp(), 0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset then idle.
        reset = 1'b0;
        step();
        chk_all("reset", '0, 0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all("idle", idle_exp(), 0, 1'b0, 1'b0);
        end

        // Directed record: 0001 through slot0, 0010 one cycle mid slot1, 1000 slot2.
        for (int i = 0; i < int'(NT); i++) begin
            seq[i] = (i < 4) ? 4'b0001 : (i < 8) ? ((i == 5) ? 4'b0010 : 4'b0000) : 4'b1000;
        end
        record("rec_dir", 1'b0, -1);
        play("play_dir", -1);

        // Both requests high: recording wins.
        fill_random();
        record("rec_both", 1'b1, -1);
        play("play_both", -1);

        // Playback aborted after 5 cycles.
        play("play_abort", 5);

        // Reset in the middle of slot1; slot0 keeps the new value.
        fill_random();
        record("rec_rst", 1'b0, 6);
        play("play_rst", -1);

        // A few more random sessions.
        for (int r = 0; r < 3; r++) begin
            fill_random();
            record("rec_rnd", 1'b0, -1);
            play("play_rnd", -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
